aes_key_schedule: RTL and testbench

Iterative AES-128 key expansion engine. It accepts a 128-bit cipher key and streams the eleven round keys (round 0 to round 10) one per handshake. A downstream round controller consumes them, and round 10 feeds the final round's AddRoundKey. Expansion is computed on the fly, one round key per accepted transfer, with no key RAM. The block holds back-pressure cleanly.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_key_step.sv | 40 ++++
 rtl/aes_sbox.sv | 44 ++++
 rtl/aes_key_schedule.sv | 89 ++++++++
 tb/tb_aes_key_schedule.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the key schedule.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  localparam int         NR        = 10;
  localparam logic [7:0] RCON_SEED = 8'h01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key expansion step: current round key + rcon -> next round key.
module aes_key_step (
  input  logic [127:0] round_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);
  import aes_pkg::*;

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot_word, sub_word, t_word;
  aes_word_t n0, n1, n2, n3;

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  assign rot_word = {w3[23:0], w3[31:24]};

  // SubWord: one S-box per byte of the rotated word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (rot_word[gi*8 +: 8]),
        .out_byte (sub_word[gi*8 +: 8])
      );
    end
  endgenerate

  assign t_word = sub_word ^ {rcon, 24'h000000};

  assign n0 = w0 ^ t_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Built from arithmetic rather than a 256-entry table so it stays generic logic.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  import aes_pkg::*;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Inverse as x^254 (maps 0 to 0) via a short square-and-multiply chain.
  assign x2   = gf_mul(in_byte, in_byte);
  assign x3   = gf_mul(x2, in_byte);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  // Affine transform: inv ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  assign out_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key schedule: accepts a cipher key and streams round
// keys 0..NR over a valid/ready handshake, computing each one on the fly.
module aes_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         abort,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_INDEX = 4'(NR);

  ks_state_t  state_reg, state_next;
  aes_block_t round_key_reg, round_key_next;
  logic [3:0] rk_index_reg, rk_index_next;
  logic [7:0] rcon_reg, rcon_next;
  aes_block_t step_key;

  aes_key_step u_step (
    .round_key (round_key_reg),
    .rcon      (rcon_reg),
    .next_key  (step_key)
  );

  // Next-state, datapath update and key_ready decode.
  always_comb begin
    state_next     = state_reg;
    round_key_next = round_key_reg;
    rk_index_next  = rk_index_reg;
    rcon_next      = rcon_reg;
    key_ready      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          round_key_next = key_in;
          rk_index_next  = 4'd0;
          rcon_next      = RCON_SEED;
          state_next     = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort wins over a simultaneous handshake
        if (abort) begin
          state_next = ST_IDLE;
        end else if (rk_ready) begin
          if (rk_index_reg == LAST_INDEX) begin
            state_next = ST_IDLE;
          end else begin
            round_key_next = step_key;
            rk_index_next  = rk_index_reg + 4'd1;
            rcon_next      = xtime(rcon_reg);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      round_key_reg <= '0;
      rk_index_reg  <= 4'd0;
      rcon_reg      <= RCON_SEED;
    end else begin
      state_reg     <= state_next;
      round_key_reg <= round_key_next;
      rk_index_reg  <= rk_index_next;
      rcon_reg      <= rcon_next;
    end
  end

  assign round_key = round_key_reg;
  assign rk_index  = rk_index_reg;
  assign rk_valid  = (state_reg == ST_RUN);
  assign rk_last   = rk_valid && (rk_index_reg == LAST_INDEX);

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: word-level FIPS-197 expansion model with a
// per-cycle compare process, plus directed scenarios with literal round keys.
module tb_aes_key_schedule;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         abort = 1'b0;
  logic         rk_ready = 1'b0;
  logic         key_ready, rk_valid, rk_last;
  logic [127:0] round_key;
  logic [3:0]   rk_index;

  always #5 clk = ~clk;

  aes_key_schedule #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .abort     (abort),
    .round_key (round_key),
    .rk_index  (rk_index),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_last   (rk_last)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_tab [0:255];
  logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [127:0] exp_rk   [0:10];

  // Carry-less product then polynomial reduction by 0x11B.
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11B << (k - 8));
    return p[7:0];
  endfunction

  // S-box by exhaustive inverse search and bitwise affine definition.
  task automatic build_sbox();
    logic [7:0] inv, b;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = b;
    end
  endtask

  // Full FIPS-197 word expansion w[0..43] into eleven round keys.
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
            ^ {rcon_tab[i/4 - 1], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- per-cycle compare process ----------------
  bit m_run   = 1'b0;
  int m_idx   = 0;
  int hs_cnt  = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rk_valid", 128'(rk_valid), 128'(1'b0));
      check("rst_key_ready", 128'(key_ready), 128'(1'b1));
      check("rst_rk_last", 128'(rk_last), 128'(1'b0));
      check("rst_round_key", round_key, 128'h0);
      check("rst_rk_index", 128'(rk_index), 128'h0);
      m_run = 1'b0;
    end else begin
      check("rk_valid", 128'(rk_valid), 128'(m_run));
      check("key_ready", 128'(key_ready), 128'(!m_run));
      check("rk_last", 128'(rk_last), 128'(m_run && m_idx == 10));
      if (m_run) begin
        check($sformatf("round_key[%0d]", m_idx), round_key, exp_rk[m_idx]);
        check("rk_index", 128'(rk_index), 128'(m_idx));
      end
      if (!m_run) begin
        if (key_valid) begin
          model_expand(key_in);
          m_run  = 1'b1;
          m_idx  = 0;
          hs_cnt = 0;
        end
      end else if (abort) begin
        m_run = 1'b0;
      end else if (rk_ready) begin
        hs_cnt++;
        if (m_idx == 10) begin
          m_run = 1'b0;
          check("keys_per_stream", 128'(hs_cnt), 128'd11);
          done_cnt++;
        end else begin
          m_idx++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input string name);
    int cyc;
    cyc = 0;
    while (done_cnt < target && cyc < 400) begin
      step();
      cyc++;
    end
    check({name, "_completed"}, 128'(done_cnt >= target), 128'(1'b1));
  endtask

  logic [127:0] hold_key;
  logic [3:0]   hold_idx;
  bit           stalled;
  int           cyc;

  initial begin
    build_sbox();
    model_expand(FIPS_KEY);
    check("model_fips_r1", exp_rk[1], FIPS_R1);
    check("model_fips_r10", exp_rk[10], FIPS_R10);
    model_expand(128'h0);
    check("model_zero_r1", exp_rk[1], ZERO_R1);

    rk_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // FIPS-197 key with rk_ready held high; cycle-exact latency checks.
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("s1_rk_last_T+%0d", k), 128'(rk_last), 128'(k == 11));
      check($sformatf("s1_key_ready_T+%0d", k), 128'(key_ready), 128'(k == 12));
      if (k == 1)  check("s1_round0", round_key, FIPS_KEY);
      if (k == 2)  check("s1_round1", round_key, FIPS_R1);
      if (k == 11) check("s1_round10", round_key, FIPS_R10);
      step();
    end
    $display("scenario fips: done_cnt=%0d", done_cnt);

    // Back-pressure: random rk_ready, stalled outputs must hold.
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    cyc = 0;
    stalled = 1'b0;
    while (done_cnt < 2 && cyc < 400) begin
      if (stalled) begin
        check("bp_hold_key", round_key, hold_key);
        check("bp_hold_idx", 128'(rk_index), 128'(hold_idx));
      end
      rk_ready = 1'($urandom_range(0, 1));
      stalled  = rk_valid && !rk_ready;
      hold_key = round_key;
      hold_idx = rk_index;
      step();
      cyc++;
    end
    check("bp_completed", 128'(done_cnt >= 2), 128'(1'b1));
    rk_ready = 1'b1;
    step();
    $display("scenario backpressure: cycles=%0d", cyc);

    // New key offered while streaming must wait until IDLE.
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    step();
    key_in = 128'h0;
    for (int k = 1; k <= 11; k++) begin
      check("run_key_ready_low", 128'(key_ready), 128'(1'b0));
      step();
    end
    check("run_idle_key_ready", 128'(key_ready), 128'(1'b1));
    step();
    key_valid = 1'b0;
    check("run_new_key_round0", round_key, 128'h0);
    check("run_new_key_index", 128'(rk_index), 128'h0);
    wait_done(4, "run_new_key");
    $display("scenario key_during_run: done_cnt=%0d", done_cnt);

    // Abort at index 4 together with rk_ready.
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    cyc = 0;
    while (rk_index != 4'd4 && cyc < 30) begin
      step();
      cyc++;
    end
    check("abort_reached_idx4", 128'(rk_index), 128'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_rk_valid", 128'(rk_valid), 128'(1'b0));
    check("abort_key_ready", 128'(key_ready), 128'(1'b1));
    key_in = 128'h0;
    key_valid = 1'b1;
    abort = 1'b1;
    step();
    key_valid = 1'b0;
    abort = 1'b0;
    check("abort_idle_accept", 128'(rk_valid), 128'(1'b1));
    step();
    check("abort_zero_r1", round_key, ZERO_R1);
    wait_done(5, "abort_zero_key");
    $display("scenario abort: done_cnt=%0d", done_cnt);

    // Asynchronous reset at index 7, away from the clock edge.
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    cyc = 0;
    while (rk_index != 4'd7 && cyc < 30) begin
      step();
      cyc++;
    end
    check("reset_reached_idx7", 128'(rk_index), 128'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_rk_valid", 128'(rk_valid), 128'(1'b0));
    check("areset_key_ready", 128'(key_ready), 128'(1'b1));
    check("areset_round_key", round_key, 128'h0);
    check("areset_rk_index", 128'(rk_index), 128'h0);
    check("areset_rk_last", 128'(rk_last), 128'(1'b0));
    step();
    step();
    rst_n = 1'b1;
    step();
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("post_reset_round0", round_key, FIPS_KEY);
    wait_done(6, "post_reset_fips");
    $display("scenario reset: done_cnt=%0d", done_cnt);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
